// File: rtl/mem_lsu_if.sv
// Request/acknowledge data bus between the memory-access stage and the data memory.
// rdata is valid in the same cycle ack is high.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores on the req/ack bus, steers store lanes, formats load
// data, and holds the pipeline through stall_req_o while an access is outstanding.
module mem_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    mem_lsu_if.master   bus
);
    localparam logic [7:0] EXE_LB  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU = 8'b1110_0101;
    localparam logic [7:0] EXE_SB  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic        err;
    logic [31:0] load_buf;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;

    logic        is_load, is_store, misaligned;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n, load_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel_n      = 4'b1111;
        wdata_n    = 32'h0;
        case (aluop_i)
            EXE_LB, EXE_LBU: is_load = 1'b1;
            EXE_LH, EXE_LHU: begin
                is_load    = 1'b1;
                misaligned = mem_addr_i[0];
            end
            EXE_LW: begin
                is_load    = 1'b1;
                misaligned = |mem_addr_i[1:0];
            end
            EXE_SB: begin
                is_store = 1'b1;
                sel_n    = 4'b0001 << mem_addr_i[1:0];
                wdata_n  = {4{reg2_i[7:0]}};
            end
            EXE_SH: begin
                is_store   = 1'b1;
                misaligned = mem_addr_i[0];
                sel_n      = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{reg2_i[15:0]}};
            end
            EXE_SW: begin
                is_store   = 1'b1;
                misaligned = |mem_addr_i[1:0];
                wdata_n    = reg2_i;
            end
            default: ;
        endcase
    end

    // The instruction is held on the inputs until DONE, so its address still selects the lane.
    always_comb begin
        byte_sel = load_buf[{mem_addr_i[1:0], 3'b000} +: 8];
        half_sel = load_buf[{mem_addr_i[1], 4'b0000} +: 16];
        case (aluop_i)
            EXE_LB:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU: load_fmt = {24'h0, byte_sel};
            EXE_LH:  load_fmt = {{16{half_sel[15]}}, half_sel};
            EXE_LHU: load_fmt = {16'h0, half_sel};
            default: load_fmt = load_buf;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        case (state)
            IDLE: begin
                if ((is_load || is_store) && misaligned) begin
                    misalign_o = 1'b1;
                    wreg_o     = 1'b0;
                end else if (is_load || is_store) begin
                    stall_req_o = 1'b1;
                    state_n     = REQ;
                end
            end
            REQ: begin
                stall_req_o = 1'b1;
                if (bus.ack || cnt == 8'(TIMEOUT_CYC - 1)) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                if (err) begin
                    bus_err_o = 1'b1;
                    wreg_o    = 1'b0;
                end else if (is_store) begin
                    wreg_o = 1'b0;
                end else begin
                    wdata_o = load_fmt;
                end
            end
            default: state_n = IDLE;
        endcase
        // Pass-through paths are combinational, so reset has to mask them explicitly.
        if (!rst_n) begin
            wd_o        = 5'h0;
            wreg_o      = 1'b0;
            wdata_o     = 32'h0;
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
            bus_err_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 8'h0;
            err      <= 1'b0;
            load_buf <= 32'h0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            sel_q    <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if ((is_load || is_store) && !misaligned) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        sel_q   <= sel_n;
                        wdata_q <= wdata_n;
                        cnt     <= 8'h0;
                        err     <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        load_buf <= bus.rdata;
                        req_q    <= 1'b0;
                    end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                        req_q <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    cnt <= 8'h0;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.sel   = sel_q;
    assign bus.wdata = wdata_q;
endmodule
